// File: rtl/opc5ls_pkg.sv
// opc5ls_pkg: state encoding and bus width defaults shared by the opc5ls memory arbiter
package opc5ls_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {
    S_CPU_A = 2'b00,
    S_CPU_D = 2'b01,
    S_DMA_A = 2'b10,
    S_DMA_D = 2'b11
  } state_t;
endpackage

// File: rtl/opc5ls_mem_arbiter.sv
// opc5ls_mem_arbiter: shares one synchronous single-port memory between the opc5ls CPU and a DMA requester
module opc5ls_mem_arbiter
  import opc5ls_pkg::*;
#(
  parameter int DMA_MAX_BURST = 4,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_rnw,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_ce,
  input  logic          dma_req,
  input  logic          dma_rnw,
  input  logic [AW-1:0] dma_address,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [3:0] MAX_BURST = 4'(DMA_MAX_BURST);
  state_t     r_state;
  logic [3:0] r_burst_cnt;
  logic [3:0] w_cnt_inc;
  logic       w_cpu_a, w_cpu_d, w_dma_a, w_dma_d, w_en;
  assign w_cpu_a   = r_state == S_CPU_A;
  assign w_cpu_d   = r_state == S_CPU_D;
  assign w_dma_a   = r_state == S_DMA_A;
  assign w_dma_d   = r_state == S_DMA_D;
  assign w_cnt_inc = (r_burst_cnt == 4'hF) ? r_burst_cnt : r_burst_cnt + 4'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= S_CPU_A;
      r_burst_cnt <= '0;
    end else
      case (r_state)
        S_CPU_A: r_state <= S_CPU_D;
        S_CPU_D: begin
          r_burst_cnt <= '0;
          r_state     <= dma_req ? S_DMA_A : S_CPU_A;
        end
        S_DMA_A: r_state <= S_DMA_D;
        default: begin
          r_burst_cnt <= w_cnt_inc;
          r_state     <= (dma_req && w_cnt_inc < MAX_BURST) ? S_DMA_A : S_CPU_A;
        end
      endcase
  // Strobes are gated by reset so an interrupted access is dropped immediately
  assign w_en        = !reset && (w_cpu_a || w_dma_a);
  assign mem_en      = w_en;
  assign mem_we      = w_en && (w_cpu_a ? !cpu_rnw : !dma_rnw);
  assign mem_address = !w_en ? '0 : w_cpu_a ? cpu_address : dma_address;
  assign mem_wdata   = !w_en ? '0 : w_cpu_a ? cpu_dout : dma_wdata;
  assign cpu_ce      = !reset && w_cpu_d;
  assign cpu_din     = w_cpu_d ? mem_rdata : '0;
  assign dma_gnt     = !reset && w_dma_a;
  assign dma_ack     = !reset && w_dma_d;
  assign dma_rdata   = w_dma_d ? mem_rdata : '0;
endmodule
